// File: rtl/bksave_pkg.sv
// rtl/bksave_pkg.sv - shared types and constants for the backup save/load controller
package bksave_pkg;

    localparam int SECTOR_WORDS = 256;
    localparam int MEM_AW       = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SD_REQ,
        ST_SD_XFER,
        ST_DRAIN,
        ST_NEXT
    } state_e;

    // Per-word SDRAM handshake: PREP gives the buffer read one cycle to settle,
    // ISSUE pulses mem_req, WAIT holds until mem_ready.
    typedef enum logic [1:0] {
        PH_PREP,
        PH_ISSUE,
        PH_WAIT
    } phase_e;

endpackage

// File: rtl/bksave_buf.sv
// rtl/bksave_buf.sv - 256x16 dual-port sector buffer with registered reads
//
// Port A (SD side):    a_addr, a_we, a_din, a_dout
// Port B (SDRAM side): b_addr, b_we, b_din, b_dout
// Both ports read with one clock of latency. Contents are not reset.
module bksave_buf (
    input  logic        clk,
    input  logic [7:0]  a_addr,
    input  logic        a_we,
    input  logic [15:0] a_din,
    output logic [15:0] a_dout,
    input  logic [7:0]  b_addr,
    input  logic        b_we,
    input  logic [15:0] b_din,
    output logic [15:0] b_dout
);

    logic [15:0] mem [0:255];
    logic [15:0] a_dout_q;
    logic [15:0] b_dout_q;

    // The controller never writes both ports in the same cycle (A only while
    // receiving a sector, B only while filling), so write order is irrelevant.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_din;
        end
        if (b_we) begin
            mem[b_addr] <= b_din;
        end
        a_dout_q <= mem[a_addr];
        b_dout_q <= mem[b_addr];
    end

    assign a_dout = a_dout_q;
    assign b_dout = b_dout_q;

endmodule

// File: rtl/bksave_ctrl.sv
// rtl/bksave_ctrl.sv - sector-by-sector backup copy between SDRAM and the HPS SD interface
//
// Ports: clk_sys/reset_n; bk_ena, load_req, save_req, last_lba triggers;
// sd_lba/sd_rd/sd_wr/sd_ack and sd_buff_* to the HPS; mem_* SDRAM word
// port with one-outstanding req/ready handshake; busy and loading status.
module bksave_ctrl
    import bksave_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR = 24'h000000,
    parameter int          MAX_LBA_W = 15
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 bk_ena,
    input  logic                 load_req,
    input  logic                 save_req,
    input  logic [MAX_LBA_W-1:0] last_lba,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    input  logic [7:0]           sd_buff_addr,
    input  logic [15:0]          sd_buff_dout,
    input  logic                 sd_buff_wr,
    output logic [15:0]          sd_buff_din,
    output logic [23:0]          mem_addr,
    output logic [15:0]          mem_din,
    input  logic [15:0]          mem_dout,
    output logic                 mem_req,
    output logic                 mem_rnw,
    input  logic                 mem_ready,
    output logic                 busy,
    output logic                 loading
);

    state_e                 state_q, state_d;
    phase_e                 phase_q, phase_d;
    logic [7:0]             idx_q, idx_d;
    logic [MAX_LBA_W-1:0]   last_lba_q, last_lba_d;
    logic [31:0]            sd_lba_q, sd_lba_d;
    logic                   loading_q, loading_d;
    logic                   busy_q, busy_d;
    logic                   sd_rd_q, sd_rd_d;
    logic                   sd_wr_q, sd_wr_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_rnw_q, mem_rnw_d;
    logic [23:0]            mem_addr_q, mem_addr_d;
    logic [15:0]            mem_din_q, mem_din_d;
    logic                   load_prev_q, save_prev_q, ack_prev_q;

    logic                   load_edge, save_edge, ack_rise, ack_fall;
    logic                   last_reached;
    logic [23:0]            sector_addr;
    logic                   buf_a_we, buf_b_we;
    logic [15:0]            buf_b_dout;

    assign load_edge    = load_req & ~load_prev_q;
    assign save_edge    = save_req & ~save_prev_q;
    assign ack_rise     = sd_ack & ~ack_prev_q;
    assign ack_fall     = ~sd_ack & ack_prev_q;
    assign last_reached = sd_lba_q >= 32'(last_lba_q);
    // sd_lba*256 truncated to 24 bits is just the low 16 bits shifted up.
    assign sector_addr  = BASE_ADDR + {sd_lba_q[15:0], idx_q};
    assign buf_a_we     = (state_q == ST_SD_XFER) && loading_q && sd_buff_wr;

    bksave_buf u_buf (
        .clk    (clk_sys),
        .a_addr (sd_buff_addr),
        .a_we   (buf_a_we),
        .a_din  (sd_buff_dout),
        .a_dout (sd_buff_din),
        .b_addr (idx_q),
        .b_we   (buf_b_we),
        .b_din  (mem_dout),
        .b_dout (buf_b_dout)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        last_lba_d = last_lba_q;
        sd_lba_d   = sd_lba_q;
        loading_d  = loading_q;
        mem_req_d  = 1'b0;
        mem_rnw_d  = mem_rnw_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        buf_b_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bk_ena && (load_edge || save_edge)) begin
                    last_lba_d = last_lba;
                    sd_lba_d   = 32'd0;
                    loading_d  = load_edge;
                    idx_d      = 8'd0;
                    phase_d    = PH_PREP;
                    state_d    = load_edge ? ST_SD_REQ : ST_FILL;
                end
            end
            ST_FILL, ST_DRAIN: begin
                case (phase_q)
                    PH_PREP: phase_d = PH_ISSUE;
                    PH_ISSUE: begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = sector_addr;
                        mem_rnw_d  = (state_q == ST_FILL);
                        if (state_q == ST_DRAIN) begin
                            mem_din_d = buf_b_dout;
                        end
                        phase_d = PH_WAIT;
                    end
                    default: begin
                        if (mem_ready) begin
                            buf_b_we = (state_q == ST_FILL);
                            idx_d    = idx_q + 8'd1;
                            phase_d  = PH_PREP;
                            if (idx_q == 8'hFF) begin
                                state_d = (state_q == ST_FILL) ? ST_SD_REQ : ST_NEXT;
                            end
                        end
                    end
                endcase
            end
            ST_SD_REQ: begin
                if (ack_rise) begin
                    state_d = ST_SD_XFER;
                end
            end
            ST_SD_XFER: begin
                if (ack_fall) begin
                    state_d = loading_q ? ST_DRAIN : ST_NEXT;
                    idx_d   = 8'd0;
                    phase_d = PH_PREP;
                end
            end
            ST_NEXT: begin
                if (last_reached) begin
                    state_d   = ST_IDLE;
                    loading_d = 1'b0;
                end else begin
                    sd_lba_d = sd_lba_q + 32'd1;
                    idx_d    = 8'd0;
                    phase_d  = PH_PREP;
                    state_d  = loading_q ? ST_SD_REQ : ST_FILL;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status and SD requests are registered images of the next state.
        busy_d  = (state_d != ST_IDLE);
        sd_rd_d = (state_d == ST_SD_REQ) && loading_d;
        sd_wr_d = (state_d == ST_SD_REQ) && !loading_d;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_PREP;
            idx_q       <= 8'd0;
            last_lba_q  <= '0;
            sd_lba_q    <= 32'd0;
            loading_q   <= 1'b0;
            busy_q      <= 1'b0;
            sd_rd_q     <= 1'b0;
            sd_wr_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_rnw_q   <= 1'b0;
            mem_addr_q  <= 24'd0;
            mem_din_q   <= 16'd0;
            load_prev_q <= 1'b0;
            save_prev_q <= 1'b0;
            ack_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            last_lba_q  <= last_lba_d;
            sd_lba_q    <= sd_lba_d;
            loading_q   <= loading_d;
            busy_q      <= busy_d;
            sd_rd_q     <= sd_rd_d;
            sd_wr_q     <= sd_wr_d;
            mem_req_q   <= mem_req_d;
            mem_rnw_q   <= mem_rnw_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            // Edge history always tracks, so triggers seen while busy never fire later.
            load_prev_q <= load_req;
            save_prev_q <= save_req;
            ack_prev_q  <= sd_ack;
        end
    end

    assign sd_lba   = sd_lba_q;
    assign sd_rd    = sd_rd_q;
    assign sd_wr    = sd_wr_q;
    assign mem_req  = mem_req_q;
    assign mem_rnw  = mem_rnw_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign busy     = busy_q;
    assign loading  = loading_q;

endmodule

// File: tb/tb_bksave_ctrl.sv
// tb/tb_bksave_ctrl.sv - directed self-checking bench for bksave_ctrl
module tb_bksave_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        bk_ena = 1'b0;
    logic        load_req = 1'b0;
    logic        save_req = 1'b0;
    logic [14:0] last_lba = 15'd0;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic        sd_ack = 1'b0;
    logic [7:0]  sd_buff_addr = 8'd0;
    logic [15:0] sd_buff_dout = 16'd0;
    logic        sd_buff_wr = 1'b0;
    logic [15:0] sd_buff_din;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout = 16'd0;
    logic        mem_req, mem_rnw;
    logic        mem_ready = 1'b0;
    logic        busy, loading;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] model_mem [0:1023];
    logic [23:0] rd_log [0:1023];
    logic [23:0] wr_addr_log [0:1023];
    logic [15:0] wr_data_log [0:1023];
    int          pend = 0;
    logic [23:0] pend_addr = 24'd0;
    logic        pend_rnw = 1'b0;
    int          rd_cnt = 0, wr_cnt = 0, overlap_cnt = 0, sd_rd_cnt = 0, sd_wr_cnt = 0;
    logic        sd_rd_prev = 1'b0, sd_wr_prev = 1'b0;

    bksave_ctrl #(.BASE_ADDR(24'h000000), .MAX_LBA_W(15)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .bk_ena       (bk_ena),
        .load_req     (load_req),
        .save_req     (save_req),
        .last_lba     (last_lba),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .mem_req      (mem_req),
        .mem_rnw      (mem_rnw),
        .mem_ready    (mem_ready),
        .busy         (busy),
        .loading      (loading)
    );

    always #5 clk_sys = ~clk_sys;

    // SDRAM model: answers each request with a one-cycle mem_ready three cycles later.
    always @(negedge clk_sys) begin
        mem_ready = 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                mem_ready = 1'b1;
                if (pend_rnw) mem_dout = model_mem[pend_addr[9:0]];
            end
        end
        if (mem_req === 1'b1) begin
            if (pend != 0) overlap_cnt++;
            pend      = 3;
            pend_addr = mem_addr;
            pend_rnw  = mem_rnw;
            if (mem_rnw) begin
                if (rd_cnt < 1024) rd_log[rd_cnt] = mem_addr;
                rd_cnt++;
            end else begin
                if (wr_cnt < 1024) begin
                    wr_addr_log[wr_cnt] = mem_addr;
                    wr_data_log[wr_cnt] = mem_din;
                end
                model_mem[mem_addr[9:0]] = mem_din;
                wr_cnt++;
            end
        end
        if (sd_rd === 1'b1 && !sd_rd_prev) sd_rd_cnt++;
        if (sd_wr === 1'b1 && !sd_wr_prev) sd_wr_cnt++;
        sd_rd_prev = (sd_rd === 1'b1);
        sd_wr_prev = (sd_wr === 1'b1);
    end

    task automatic clear_counts();
        rd_cnt = 0; wr_cnt = 0; overlap_cnt = 0; sd_rd_cnt = 0; sd_wr_cnt = 0;
    endtask

    task automatic wait_until(input int sel, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys);
            if ((sel == 0 && sd_rd === 1'b1) || (sel == 1 && sd_wr === 1'b1) ||
                (sel == 2 && busy === 1'b0)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic hps_save_sector(input int lba);
        bit ok;
        logic [15:0] exp;
        wait_until(1, 5000, ok);
        vectors++;
        if (!ok) begin
            $display("FAIL save_sd_wr_timeout lba %0d: sd_wr=%b required 1", lba, sd_wr);
            miscompares++;
            return;
        end
        vectors++;
        if (sd_lba !== 32'(lba)) begin
            $display("FAIL save_sd_lba: got %0d required %0d", sd_lba, lba);
            miscompares++;
        end
        sd_ack = 1'b1;
        @(negedge clk_sys);
        vectors++;
        if (sd_wr !== 1'b0) begin
            $display("FAIL save_sd_wr_clear: got %b required 0", sd_wr);
            miscompares++;
        end
        for (int a = 0; a < 256; a++) begin
            sd_buff_addr = 8'(a);
            @(negedge clk_sys);
            exp = model_mem[lba * 256 + a];
            vectors++;
            if (sd_buff_din !== exp) begin
                $display("FAIL save_buff_din lba %0d addr %0d: got %h required %h", lba, a, sd_buff_din, exp);
                miscompares++;
            end
        end
        sd_ack = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic hps_load_sector(input int lba, input logic [15:0] pattern);
        bit ok;
        wait_until(0, 5000, ok);
        vectors++;
        if (!ok) begin
            $display("FAIL load_sd_rd_timeout lba %0d: sd_rd=%b required 1", lba, sd_rd);
            miscompares++;
            return;
        end
        vectors++;
        if (sd_lba !== 32'(lba)) begin
            $display("FAIL load_sd_lba: got %0d required %0d", sd_lba, lba);
            miscompares++;
        end
        sd_ack = 1'b1;
        @(negedge clk_sys);
        vectors++;
        if (sd_rd !== 1'b0) begin
            $display("FAIL load_sd_rd_clear: got %b required 0", sd_rd);
            miscompares++;
        end
        for (int a = 0; a < 256; a++) begin
            sd_buff_addr = 8'(a);
            sd_buff_dout = pattern + 16'(a);
            sd_buff_wr   = 1'b1;
            @(negedge clk_sys);
        end
        sd_buff_wr = 1'b0;
        @(negedge clk_sys);
        sd_ack = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic check_outputs_zero(input string tag);
        vectors++;
        if ({sd_rd, sd_wr, mem_req, busy, loading, mem_rnw} !== 6'b0 || sd_lba !== 32'd0 ||
            mem_addr !== 24'd0 || mem_din !== 16'd0) begin
            $display("FAIL %s: rd=%b wr=%b req=%b busy=%b loading=%b rnw=%b lba=%0h addr=%0h din=%0h required all 0",
                     tag, sd_rd, sd_wr, mem_req, busy, loading, mem_rnw, sd_lba, mem_addr, mem_din);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_sys);
        check_outputs_zero("reset_outputs");
        reset_n = 1'b1;
        @(negedge clk_sys);
        check_outputs_zero("idle_after_reset");
    endtask

    task automatic test_disabled_trigger();
        bk_ena = 1'b0;
        clear_counts();
        load_req = 1'b1; save_req = 1'b1;
        @(negedge clk_sys);
        load_req = 1'b0; save_req = 1'b0;
        repeat (10) @(negedge clk_sys);
        vectors++;
        if (busy !== 1'b0 || rd_cnt + wr_cnt + sd_rd_cnt + sd_wr_cnt != 0) begin
            $display("FAIL disabled_trigger: busy=%b activity=%0d required 0", busy, rd_cnt + wr_cnt + sd_rd_cnt + sd_wr_cnt);
            miscompares++;
        end
    endtask

    task automatic test_save();
        bit ok;
        int bad;
        bk_ena = 1'b1;
        last_lba = 15'd1;
        clear_counts();
        save_req = 1'b1;
        @(negedge clk_sys);
        vectors++;
        if (busy !== 1'b1 || loading !== 1'b0) begin
            $display("FAIL save_start: busy=%b loading=%b required 1/0", busy, loading);
            miscompares++;
        end
        save_req = 1'b0;
        repeat (5) @(negedge clk_sys);
        save_req = 1'b1;
        @(negedge clk_sys);
        save_req = 1'b0;
        load_req = 1'b1;
        @(negedge clk_sys);
        load_req = 1'b0;
        bk_ena = 1'b0;
        hps_save_sector(0);
        hps_save_sector(1);
        wait_until(2, 200, ok);
        vectors++;
        if (!ok) begin
            $display("FAIL save_done_timeout: busy=%b required 0", busy);
            miscompares++;
        end
        vectors++;
        if (rd_cnt != 512 || wr_cnt != 0) begin
            $display("FAIL save_mem_counts: reads=%0d writes=%0d required 512/0", rd_cnt, wr_cnt);
            miscompares++;
        end
        bad = 0;
        for (int i = 0; i < 512; i++) if (rd_log[i] !== 24'(i)) bad++;
        vectors++;
        if (bad != 0) begin
            $display("FAIL save_read_addrs: %0d out-of-order addresses required 0", bad);
            miscompares++;
        end
        vectors++;
        if (sd_wr_cnt != 2 || sd_rd_cnt != 0 || overlap_cnt != 0) begin
            $display("FAIL save_sd_counts: sd_wr=%0d sd_rd=%0d overlap=%0d required 2/0/0", sd_wr_cnt, sd_rd_cnt, overlap_cnt);
            miscompares++;
        end
        repeat (20) @(negedge clk_sys);
        vectors++;
        if (busy !== 1'b0 || loading !== 1'b0) begin
            $display("FAIL save_no_stale_edge: busy=%b loading=%b required 0/0", busy, loading);
            miscompares++;
        end
        bk_ena = 1'b1;
    endtask

    task automatic test_load();
        bit ok;
        bk_ena = 1'b1;
        last_lba = 15'd0;
        clear_counts();
        load_req = 1'b1;
        @(negedge clk_sys);
        vectors++;
        if (busy !== 1'b1 || loading !== 1'b1) begin
            $display("FAIL load_start: busy=%b loading=%b required 1/1", busy, loading);
            miscompares++;
        end
        load_req = 1'b0;
        hps_load_sector(0, 16'hA500);
        wait_until(2, 3000, ok);
        vectors++;
        if (!ok || loading !== 1'b0) begin
            $display("FAIL load_done: busy=%b loading=%b required 0/0", busy, loading);
            miscompares++;
        end
        vectors++;
        if (wr_cnt != 256 || rd_cnt != 0) begin
            $display("FAIL load_mem_counts: writes=%0d reads=%0d required 256/0", wr_cnt, rd_cnt);
            miscompares++;
        end
        for (int i = 0; i < 256; i++) begin
            vectors++;
            if (wr_addr_log[i] !== 24'(i) || wr_data_log[i] !== 16'hA500 + 16'(i)) begin
                $display("FAIL load_write %0d: addr=%h data=%h required %h/%h", i, wr_addr_log[i], wr_data_log[i], 24'(i), 16'hA500 + 16'(i));
                miscompares++;
            end
        end
    endtask

    task automatic test_simultaneous_and_stall();
        bit ok;
        int drops;
        last_lba = 15'd0;
        clear_counts();
        load_req = 1'b1; save_req = 1'b1;
        @(negedge clk_sys);
        vectors++;
        if (busy !== 1'b1 || loading !== 1'b1 || sd_rd !== 1'b1 || sd_wr !== 1'b0) begin
            $display("FAIL both_edges: busy=%b loading=%b sd_rd=%b sd_wr=%b required 1/1/1/0", busy, loading, sd_rd, sd_wr);
            miscompares++;
        end
        load_req = 1'b0; save_req = 1'b0;
        drops = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_sys);
            if (sd_rd !== 1'b1 || sd_lba !== 32'd0) drops++;
        end
        vectors++;
        if (drops != 0 || rd_cnt + wr_cnt != 0) begin
            $display("FAIL ack_stall: drops=%0d mem_ops=%0d required 0/0", drops, rd_cnt + wr_cnt);
            miscompares++;
        end
        hps_load_sector(0, 16'h1200);
        wait_until(2, 3000, ok);
        vectors++;
        if (!ok || wr_cnt != 256 || rd_cnt != 0 || wr_data_log[7] !== 16'h1207) begin
            $display("FAIL stall_complete: busy=%b writes=%0d reads=%0d data7=%h required 0/256/0/1207", busy, wr_cnt, rd_cnt, wr_data_log[7]);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_xfer();
        bit ok;
        last_lba = 15'd3;
        clear_counts();
        load_req = 1'b1;
        @(negedge clk_sys);
        load_req = 1'b0;
        hps_load_sector(0, 16'h3000);
        hps_load_sector(1, 16'h3100);
        wait_until(0, 5000, ok);
        vectors++;
        if (!ok || sd_lba !== 32'd2) begin
            $display("FAIL reset_reach_lba2: sd_rd=%b sd_lba=%0d required 1/2", sd_rd, sd_lba);
            miscompares++;
        end
        sd_ack = 1'b1;
        repeat (2) @(negedge clk_sys);
        sd_buff_wr = 1'b1;
        repeat (4) @(negedge clk_sys);
        load_req = 1'b1;
        last_lba = 15'd0;
        #2 reset_n = 1'b0;
        #1 check_outputs_zero("async_reset_mid_xfer");
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        pend = 0;
        repeat (2) @(negedge clk_sys);
        clear_counts();
        reset_n = 1'b1;
        @(negedge clk_sys);
        vectors++;
        if (busy !== 1'b1 || loading !== 1'b1 || sd_lba !== 32'd0 || sd_rd !== 1'b1) begin
            $display("FAIL held_trigger_after_reset: busy=%b loading=%b lba=%0d sd_rd=%b required 1/1/0/1", busy, loading, sd_lba, sd_rd);
            miscompares++;
        end
        load_req = 1'b0;
        hps_load_sector(0, 16'h7700);
        wait_until(2, 3000, ok);
        vectors++;
        if (!ok || wr_cnt != 256 || wr_addr_log[255] !== 24'd255 || wr_data_log[255] !== 16'h77FF) begin
            $display("FAIL reload_after_reset: busy=%b writes=%0d last=%h/%h required 0/256/ff/77ff", busy, wr_cnt, wr_addr_log[255], wr_data_log[255]);
            miscompares++;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model_mem[i] = 16'(i * 37) ^ 16'h5A5A;
        test_reset();
        test_disabled_trigger();
        test_save();
        test_load();
        test_simultaneous_and_stall();
        test_reset_mid_xfer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bksave_ctrl.md
BKSAVE_CTRL -- requirements
Module: bksave_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 24'h000000, SDRAM 16-bit word address of sector 0 of the backup region.
REQ-002 SHALL have parameter MAX_LBA_W, default 15, width of last_lba.
REQ-003 clk_sys  in  1  system clock; the only clock.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 bk_ena  in  1  backup enabled; triggers are ignored while low.
REQ-006 load_req  in  1  level; rising edge starts a load (SD -> SDRAM).
REQ-007 save_req  in  1  level; rising edge starts a save (SDRAM -> SD).
REQ-008 last_lba  in  MAX_LBA_W  index of the last sector to transfer; sampled at start.
REQ-009 sd_lba  out  32  current sector number.
REQ-010 sd_rd / sd_wr  out  1 each  sector read / write request to HPS.
REQ-011 sd_ack  in  1  HPS acknowledge; high for the duration of the sector transfer.
REQ-012 sd_buff_addr  in  8  word index within the sector.
REQ-013 sd_buff_dout  in  16  sector data from HPS.
REQ-014 sd_buff_wr  in  1  write strobe for sd_buff_dout.
REQ-015 sd_buff_din  out  16  sector data to HPS; buffer[sd_buff_addr] registered, 1-cycle latency.
REQ-016 mem_addr  out  24  SDRAM word address.
REQ-017 mem_din  out  16  write data; mem_dout  in  16  read data.
REQ-018 mem_req  out  1  one-cycle request pulse; mem_rnw  out  1  1 = read.
REQ-019 mem_ready  in  1  one-cycle completion pulse; mem_dout is valid in the same cycle.
REQ-020 busy  out  1  high from start until return to IDLE; loading  out  1  high during a load.

Function
REQ-021 SHALL implement states IDLE, FILL, SD_REQ, SD_XFER, DRAIN and NEXT.
REQ-022 IDLE: a rising edge of load_req or save_req with bk_ena=1 SHALL latch last_lba, set sd_lba=0 and set loading; load SHALL win when both edges occur in the same cycle.
REQ-023 A save SHALL enter FILL; a load SHALL enter SD_REQ.
REQ-024 FILL: SHALL issue 256 sequential reads at mem_addr = BASE_ADDR + sd_lba*256 + idx, with idx 0..255.
- Each mem_ready writes mem_dout into buffer[idx].
- The next mem_req is issued no earlier than the cycle after mem_ready.
- Only one request is outstanding at a time.
- After idx 255 completes, go to SD_REQ.
REQ-025 SD_REQ: SHALL assert sd_rd (load) or sd_wr (save) and hold it until sd_ack rises; both SHALL clear on the cycle after sd_ack rises; then go to SD_XFER.
REQ-026 SD_XFER: each sd_buff_wr during a load SHALL write sd_buff_dout to buffer[sd_buff_addr]; sd_buff_din SHALL be served continuously.
REQ-027 SD_XFER: on a falling edge of sd_ack, a load SHALL go to DRAIN and a save SHALL go to NEXT.
REQ-028 DRAIN: SHALL issue 256 writes of buffer[idx] to the same addresses as FILL, with the same one-outstanding handshake, then go to NEXT.
REQ-029 NEXT: if sd_lba >= last_lba (zero-extended), SHALL go to IDLE and clear busy and loading.
REQ-030 NEXT: otherwise SHALL increment sd_lba and go to FILL (save) or SD_REQ (load).
REQ-031 sd_lba*256 arithmetic SHALL be truncated to 24 bits; wrap-around is not detected.
REQ-032 Triggers received while busy SHALL be ignored; edge detectors SHALL keep tracking so no stale edge fires later.
REQ-033 A drop of bk_ena while busy SHALL NOT abort the transfer.
REQ-034 mem_ready outside FILL or DRAIN SHALL be ignored.

Reset
REQ-035 reset_n low SHALL force IDLE immediately, including mid-sector.
REQ-036 During reset: sd_rd, sd_wr, mem_req, busy and loading SHALL be 0; sd_lba SHALL be 0; mem_addr, mem_din and mem_rnw SHALL be 0.
REQ-037 During reset, the edge-detector history SHALL be 0, so a trigger held high through reset starts a transfer on the first clock after release.
REQ-038 Buffer contents are not reset.

Structure
REQ-039 SHALL provide a shared package bksave_pkg containing the state enum, SECTOR_WORDS=256 and the word-address width constant.
REQ-040 SHALL instantiate one sub-module bksave_buf: a 256x16 dual-port RAM.
- Port A: SD side.
- Port B: SDRAM side.
- Registered reads, one clock.

Verification
REQ-041 Save with last_lba=1, memory model with 3-cycle mem_ready -> 512 reads at 0..511, then sd_wr at lba 0 and lba 1, with sd_buff_din matching memory per address.
REQ-042 Load with last_lba=0, HPS model writes pattern 16'hA500+addr -> 256 writes of 16'hA500..16'hA5FF to BASE_ADDR..BASE_ADDR+255; busy low afterwards.
REQ-043 load_req and save_req rising in the same cycle -> load only (loading=1, sd_rd=1, no mem reads).
REQ-044 save_req pulse while busy, and any trigger with bk_ena=0 -> ignored; sector count is unchanged.
REQ-045 reset_n asserted during SD_XFER of lba 2 -> all outputs 0 asynchronously; a new load after release starts at lba 0.
REQ-046 sd_ack held low for 1000 cycles after sd_rd -> sd_rd stays 1 with no state advance; ack rise -> sd_rd clears on the next cycle.
